// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//   Single-clock FIFO with occupancy count, registered status flags,
//   programmable almost-full / almost-empty thresholds and sticky
//   overflow / underflow error flags.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word fall-through: data_out shows the
//                              head word combinationally (undefined while empty)
//                 undefined -> data_out is registered and updates one cycle
//                              after an accepted read, holding otherwise
//
// Parameters:
//   DEPTH      entries (power of two, >= 2)
//   WIDTH      data word width
//   AF_THRESH  almost_full  when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   w_en/data_in  write request and data
//   r_en/data_out read request and data
//   full, empty, almost_full, almost_empty, count   registered status
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module param_sync_fifo #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       r_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             wr_acc;
   logic             rd_acc;

   // Acceptance is judged against the registered flags, so a full FIFO
   // refuses a write even when a read frees a slot on the same edge
   // (and symmetrically for empty).
   assign wr_acc = w_en && !full;
   assign rd_acc = r_en && !empty;

   // Occupancy after this edge; acceptance gating keeps it in 0..DEPTH.
   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)
         count_nxt = count + CW'(1);
      else if (rd_acc && !wr_acc)
         count_nxt = count - CW'(1);
   end

   // Storage carries no reset: stale words are unreachable once the
   // pointers are cleared.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr] <= data_in;
   end

   // Pointers, count and flags. DEPTH is a power of two, so the pointer
   // increment wraps modulo DEPTH on its own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc)
            rd_ptr <= rd_ptr + AW'(1);
         count        <= count_nxt;
         full         <= (count_nxt == CW'(DEPTH));
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= CW'(AF_THRESH));
         almost_empty <= (count_nxt <= CW'(AE_THRESH));
         if (w_en && full)
            overflow <= 1'b1;
         if (r_en && empty)
            underflow <= 1'b1;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word shown directly; a read just advances rd_ptr.
   assign data_out = mem[rd_ptr];
`else
   logic [WIDTH-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (rst)
         dout_q <= '0;
      else if (rd_acc)
         dout_q <= mem[rd_ptr];
   end

   assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

   localparam int D  = 8;
   localparam int W  = 8;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic [W-1:0]  data_in = '0;
   logic [W-1:0]  data_out;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [CW-1:0] count;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   // bench-side model
   logic [W-1:0] sb [$];
   int           mcount = 0;
   logic         movf = 1'b0;
   logic         munf = 1'b0;
   logic [W-1:0] mdout = '0;

   always #5 clk = ~clk;

   param_sync_fifo #(.DEPTH(D), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(mcount));
      chk({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
      chk({tag, ".full"},  32'(full),  32'(mcount == D));
      chk({tag, ".af"},    32'(almost_full),  32'(mcount >= D - 1));
      chk({tag, ".ae"},    32'(almost_empty), 32'(mcount <= 1));
      chk({tag, ".ovf"},   32'(overflow),  32'(movf));
      chk({tag, ".unf"},   32'(underflow), 32'(munf));
`ifndef FIFO_FWFT_EN
      chk({tag, ".dout"},  32'(data_out), 32'(mdout));
`endif
   endtask

   // One clock with the given requests; the model decides acceptance.
   task automatic cyc(input string tag, input logic we, input logic [W-1:0] d, input logic re);
      bit aw, ar;
      aw = we && (mcount != D);
      ar = re && (mcount != 0);
      w_en = we; data_in = d; r_en = re;
`ifdef FIFO_FWFT_EN
      // zero latency: the head word is visible before the read edge
      if (ar) chk({tag, ".fwft_head"}, 32'(data_out), 32'(sb[0]));
`endif
      if (we && mcount == D) movf = 1'b1;
      if (re && mcount == 0) munf = 1'b1;
      if (ar) mdout = sb.pop_front();
      if (aw) sb.push_back(d);
      mcount = mcount + int'(aw) - int'(ar);
      @(posedge clk); #1;
      w_en = 1'b0; r_en = 1'b0;
      chk_state(tag);
   endtask

   task automatic rst_cyc(input string tag, input logic we);
      rst = 1'b1; w_en = we; data_in = 8'hEE; r_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; w_en = 1'b0;
      sb.delete();
      mcount = 0; movf = 1'b0; munf = 1'b0; mdout = '0;
      chk_state(tag);
   endtask

   initial begin
      // reset state
      rst_cyc("reset", 1'b0);

      // basic three-word write/read
      cyc("w11", 1'b1, 8'h11, 1'b0);
      cyc("w22", 1'b1, 8'h22, 1'b0);
      cyc("w33", 1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) cyc("rd3", 1'b0, '0, 1'b1);

      // read while empty -> underflow, data_out held
      cyc("uflow", 1'b0, '0, 1'b1);
      cyc("uflow_hold", 1'b0, '0, 1'b0);

      // fill to full, then overflow write, then drain to confirm contents
      for (int i = 0; i < D; i++) cyc("fill", 1'b1, 8'(8'hA0 + i), 1'b0);
      cyc("oflow", 1'b1, 8'h5A, 1'b0);
      for (int i = 0; i < D; i++) cyc("drain", 1'b0, '0, 1'b1);

      // both requests at full: write refused, count 8->7
      for (int i = 0; i < D; i++) cyc("fill2", 1'b1, 8'(8'hC0 + i), 1'b0);
      cyc("full_both", 1'b1, 8'h99, 1'b1);
      for (int i = 0; i < D - 1; i++) cyc("drain2", 1'b0, '0, 1'b1);
      // both requests at empty: read refused, count 0->1
      cyc("empty_both", 1'b1, 8'h77, 1'b1);
      cyc("drain3", 1'b0, '0, 1'b1);

      // wrap: count oscillates 1<->2 with incrementing data
      cyc("wrap_pre", 1'b1, 8'h00, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cyc("wrap_w", 1'b1, 8'(i), 1'b0);
         cyc("wrap_r", 1'b0, '0, 1'b1);
      end
      cyc("wrap_last", 1'b0, '0, 1'b1);

      // reset mid-operation with count=5 and a concurrent write
      for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 8'(8'h50 + i), 1'b0);
      rst_cyc("mid_rst", 1'b1);
      cyc("post_rst_w", 1'b1, 8'h3C, 1'b0);
      cyc("post_rst_r", 1'b0, '0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, >= 2).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-1, meaning the count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_THRESH, default 1, meaning the count at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-007 The block SHALL have port w_en, input, 1, write request.
REQ-008 The block SHALL have port data_in, input, WIDTH, write data.
REQ-009 The block SHALL have port r_en, input, 1, read request.
REQ-010 The block SHALL have port data_out, output, WIDTH, read data.
REQ-011 The block SHALL have port full, output, 1, asserted when count == DEPTH.
REQ-012 The block SHALL have port empty, output, 1, asserted when count == 0.
REQ-013 The block SHALL have port almost_full, output, 1, asserted when count >= AF_THRESH.
REQ-014 The block SHALL have port almost_empty, output, 1, asserted when count <= AE_THRESH.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
REQ-016 The block SHALL have port overflow, output, 1, sticky flag for a write attempted while full.
REQ-017 The block SHALL have port underflow, output, 1, sticky flag for a read attempted while empty.

Function
REQ-018 Write SHALL be accepted iff w_en && !full; data_in is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-019 Read SHALL be accepted iff r_en && !empty; rd_ptr increments modulo DEPTH.
REQ-020 full, empty, almost_full, almost_empty and count SHALL be registered and reflect the state after the current edge, one cycle after the accepted operation.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged and move both pointers.
REQ-022 When full, a write SHALL be rejected even if a read is accepted in the same cycle; count decrements by 1.
REQ-023 When empty, a read SHALL be rejected even if a write is accepted in the same cycle; count increments by 1.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order is strictly first-in first-out.
REQ-025 overflow SHALL set on the edge where w_en && full and hold until reset; underflow SHALL set on the edge where r_en && empty and hold until reset.
REQ-026 Rejected operations SHALL NOT modify memory, pointers, count or data_out.
REQ-027 count arithmetic SHALL never exceed DEPTH or drop below 0.

Reset
REQ-028 With rst high at a clk edge, the block SHALL clear wr_ptr, rd_ptr, count, overflow, underflow and data_out to 0, and set empty=1, full=0, almost_empty=1, almost_full=0.
REQ-029 Reset SHALL override any w_en/r_en in the same cycle; memory contents need not be cleared.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; the first read after reset returns the first word written after reset.

Configuration
REQ-031 Macro FIFO_FWFT_EN defined: data_out SHALL continuously present mem[rd_ptr] (first-word fall-through); an accepted read advances to the next word; data_out is undefined while empty.
REQ-032 Macro FIFO_FWFT_EN undefined: data_out SHALL be registered, updating to the read word one cycle after an accepted read and holding otherwise.

Verification
REQ-033 Reset, then write 0x11,0x22,0x33 on consecutive cycles -> count=3, empty=0; reading three times returns 0x11,0x22,0x33, then empty=1.
REQ-034 DEPTH=8: write 8 words -> full=1, almost_full=1 from count=7; 9th write -> overflow=1, count stays 8, contents unchanged.
REQ-035 Read while empty -> underflow=1, count=0, data_out unchanged; flag persists until rst.
REQ-036 Full FIFO with w_en=r_en=1 -> write rejected, count 8->7; empty FIFO with both -> read rejected, count 0->1.
REQ-037 Wrap: perform 20 interleaved write/read pairs with count oscillating between 1 and 2 and incrementing data -> output sequence matches input, no gaps.
REQ-038 Assert rst with count=5 and w_en=1 -> next cycle count=0, empty=1, overflow=underflow=0; run the bench both with and without FIFO_FWFT_EN, checking latency 0 vs 1.
